// File: rtl/seg7_pkg.sv
// Shared types and constants for the dual-digit 7-segment scan controller.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package seg7_pkg;

    typedef enum logic [1:0] {
        SHOW_LO  = 2'd0,
        BLANK_LO = 2'd1,
        SHOW_HI  = 2'd2,
        BLANK_HI = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry [n] is the pattern for hex digit n; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31,
        7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C,
        7'h06, 7'h12, 7'h4F, 7'h01
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Value-load handshake between a value source (master) and the scan controller (slave).
interface seg7_scan_ctrl_if;
    logic [7:0] value_i;
    logic       value_valid;
    logic       value_ready;

    modport master (output value_i, output value_valid, input value_ready);
    modport slave  (input value_i, input value_valid, output value_ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller with frame-aligned value updates.
// Optional leading-zero blanking of the high digit with SEG7_LZB_EN.
//
// state    | meaning
// SHOW_LO  | low nibble lit, dig_sel=0, DIGIT_CYCLES long
// BLANK_LO | segments off, dig_sel held, BLANK_CYCLES long
// SHOW_HI  | high nibble lit, dig_sel=1, DIGIT_CYCLES long
// BLANK_HI | segments off, last cycle is the frame boundary
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 12000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   bus,
    output logic [6:0]        seg,
    output logic              dig_sel,
    output logic              frame_done
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    disp_q, disp_d;
    logic [7:0]    pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic [6:0]    seg_q, seg_d;
    logic          dig_sel_q, dig_sel_d;
    logic          ready_q, ready_d;
    logic          frame_done_q, frame_done_d;

    logic [CW-1:0] last_cnt;
    logic          dwell_end;
    logic          boundary;
    logic          xfer;
    logic [3:0]    nib;
    logic [6:0]    nib_seg;

    seg7_hex_decode u_dec (
        .hex_i (nib),
        .seg_o (nib_seg)
    );

    always_comb begin
        last_cnt = ((state_q == SHOW_LO) || (state_q == SHOW_HI)) ?
                   CW'(DIGIT_CYCLES - 1) : CW'(BLANK_CYCLES - 1);
        dwell_end = (cnt_q == last_cnt);

        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (dwell_end) begin
            cnt_d = '0;
            case (state_q)
                SHOW_LO:  state_d = BLANK_LO;
                BLANK_LO: state_d = SHOW_HI;
                SHOW_HI:  state_d = BLANK_HI;
                default:  state_d = SHOW_LO;
            endcase
        end

        boundary = dwell_end && (state_q == BLANK_HI);
        xfer     = bus.value_valid && ready_q;

        // A transfer needs ready (pend clear), so it never collides with a boundary swap.
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (boundary && pend_q) begin
            disp_d = pend_val_q;
            pend_d = 1'b0;
        end
        if (xfer) begin
            pend_val_d = bus.value_i;
            pend_d     = 1'b1;
        end
        ready_d = !pend_d;

        frame_done_d = (state_d == BLANK_HI) && (cnt_d == CW'(BLANK_CYCLES - 1));

        nib       = (state_d == SHOW_HI) ? disp_d[7:4] : disp_d[3:0];
        seg_d     = SEG_BLANK;
        dig_sel_d = dig_sel_q;
        case (state_d)
            SHOW_LO: begin
                seg_d     = nib_seg;
                dig_sel_d = 1'b0;
            end
            SHOW_HI: begin
`ifdef SEG7_LZB_EN
                seg_d     = (disp_d[7:4] == 4'h0) ? SEG_BLANK : nib_seg;
`else
                seg_d     = nib_seg;
`endif
                dig_sel_d = 1'b1;
            end
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BLANK_HI;
            cnt_q        <= '0;
            disp_q       <= 8'h00;
            pend_val_q   <= 8'h00;
            pend_q       <= 1'b0;
            seg_q        <= SEG_BLANK;
            dig_sel_q    <= 1'b0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_val_q   <= pend_val_d;
            pend_q       <= pend_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg             = seg_q;
    assign dig_sel         = dig_sel_q;
    assign frame_done      = frame_done_q;
    assign bus.value_ready = ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2 (20-cycle frame).
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic       dig_sel;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] HI0 = 7'h7F;
`else
    localparam logic [6:0] HI0 = 7'h01;
`endif

    seg7_scan_ctrl_if vif ();

    seg7_scan_ctrl #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (vif.slave),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp);
        end
    endtask

    // Check the current cycle against its place in the frame, then advance one cycle.
    task automatic tick(input logic [6:0] lo, input logic [6:0] hi);
        logic [6:0] e_seg;
        logic       e_dig;
        logic       e_fd;
        if (pos < 8) begin
            e_seg = lo;   e_dig = 1'b0;
        end else if (pos < 10) begin
            e_seg = 7'h7F; e_dig = 1'b0;
        end else if (pos < 18) begin
            e_seg = hi;   e_dig = 1'b1;
        end else begin
            e_seg = 7'h7F; e_dig = 1'b1;
        end
        e_fd = (pos == 19);
        chk("seg",        {1'b0, seg},        {1'b0, e_seg});
        chk("dig_sel",    {7'b0, dig_sel},    {7'b0, e_dig});
        chk("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
        step();
        pos = (pos + 1) % 20;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_seg",        {1'b0, seg},              8'h7F);
        chk("rst_dig_sel",    {7'b0, dig_sel},          8'h00);
        chk("rst_frame_done", {7'b0, frame_done},       8'h00);
        chk("rst_ready",      {7'b0, vif.value_ready},  8'h01);
    endtask

    // Initial blank after reset release: two blank cycles, frame_done on the second.
    task automatic init_blank();
        chk("init_seg0", {1'b0, seg},        8'h7F);
        chk("init_dig0", {7'b0, dig_sel},    8'h00);
        chk("init_fd0",  {7'b0, frame_done}, 8'h00);
        step();
        chk("init_seg1", {1'b0, seg},        8'h7F);
        chk("init_dig1", {7'b0, dig_sel},    8'h00);
        chk("init_fd1",  {7'b0, frame_done}, 8'h01);
        step();
        pos = 0;
    endtask

    task automatic chk_ready(input logic exp);
        chk("value_ready", {7'b0, vif.value_ready}, {7'b0, exp});
    endtask

    initial begin
        rst = 1'b1;
        vif.value_valid = 1'b0;
        vif.value_i     = 8'h00;
        repeat (3) step();
        chk_reset_outputs();
        rst = 1'b0;
        init_blank();

        // Idle display of 0x00
        chk_ready(1'b1);
        repeat (20) tick(7'h01, HI0);

        // Load 0x3A mid-SHOW_HI
        repeat (12) tick(7'h01, HI0);
        chk_ready(1'b1);
        vif.value_valid = 1'b1; vif.value_i = 8'h3A;
        tick(7'h01, HI0);
        vif.value_valid = 1'b0; vif.value_i = 8'hFF;
        chk_ready(1'b0);
        repeat (7) tick(7'h01, HI0);
        chk_ready(1'b1);
        repeat (20) tick(7'h08, 7'h06);

        // Back-to-back 0x12 then 0x34 held valid across the boundary
        repeat (2) tick(7'h08, 7'h06);
        vif.value_valid = 1'b1; vif.value_i = 8'h12;
        tick(7'h08, 7'h06);
        vif.value_i = 8'h34;
        chk_ready(1'b0);
        repeat (16) tick(7'h08, 7'h06);
        chk_ready(1'b0);
        tick(7'h08, 7'h06);
        chk_ready(1'b1);
        tick(7'h12, 7'h4F);
        vif.value_valid = 1'b0;
        chk_ready(1'b0);
        repeat (19) tick(7'h12, 7'h4F);
        repeat (20) tick(7'h4C, 7'h06);

        // Valid first raised exactly on the boundary cycle while pending
        repeat (5) tick(7'h4C, 7'h06);
        vif.value_valid = 1'b1; vif.value_i = 8'h56;
        tick(7'h4C, 7'h06);
        vif.value_valid = 1'b0;
        chk_ready(1'b0);
        repeat (13) tick(7'h4C, 7'h06);
        vif.value_valid = 1'b1; vif.value_i = 8'h78;
        chk_ready(1'b0);
        tick(7'h4C, 7'h06);
        chk_ready(1'b1);
        tick(7'h20, 7'h24);
        vif.value_valid = 1'b0;
        chk_ready(1'b0);
        repeat (19) tick(7'h20, 7'h24);
        repeat (20) tick(7'h00, 7'h0F);

        // Reset mid-SHOW_LO with 0x9C pending
        repeat (2) tick(7'h00, 7'h0F);
        vif.value_valid = 1'b1; vif.value_i = 8'h9C;
        tick(7'h00, 7'h0F);
        vif.value_valid = 1'b0;
        chk_ready(1'b0);
        tick(7'h00, 7'h0F);
        rst = 1'b1;
        step();
        chk_reset_outputs();
        rst = 1'b0;
        init_blank();
        repeat (40) tick(7'h01, HI0);
        chk_ready(1'b1);

        // Value 0x05: high digit depends on leading-zero blanking
        vif.value_valid = 1'b1; vif.value_i = 8'h05;
        tick(7'h01, HI0);
        vif.value_valid = 1'b0;
        chk_ready(1'b0);
        repeat (19) tick(7'h01, HI0);
        repeat (20) tick(7'h24, HI0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
